// File: rtl/cordic_frame_tx.sv
// Buffers CORDIC results in a small FIFO and sends each as a serial frame with retransmission on nack/timeout.
// Optional build macro FRAME_CRC4_EN replaces the even-parity trailer with a 4-bit CRC (x^4+x+1).
module cordic_frame_tx #(
  parameter int unsigned n           = 16,
  parameter int unsigned depth_log2  = 2,
  parameter int unsigned max_retry   = 3,
  parameter int unsigned ack_timeout = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       input_valid,
  input  logic [n:1] input_num,
  input  logic       ack,
  input  logic       nack,
  output logic       tx_data,
  output logic       tx_frame,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << depth_log2;
`ifdef FRAME_CRC4_EN
  localparam int unsigned L = n + 4;
`else
  localparam int unsigned L = n + 1;
`endif
  localparam int unsigned PW = depth_log2 + 1;
  localparam int unsigned CW = $clog2(L + 1);
  localparam int unsigned TW = $clog2(ack_timeout);
  localparam int unsigned RW = $clog2(max_retry + 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t            state_q, state_d;
  logic [n-1:0]      mem_q [DEPTH];
  logic [n-1:0]      mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [L-1:0]      sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              tx_data_q, tx_data_d, tx_frame_q, tx_frame_d;
  logic              tx_done_q, tx_done_d, tx_fail_q, tx_fail_d;
  logic              overflow_q, overflow_d;

  logic [n-1:0]      head;
  logic [L-1:0]      frame;
  logic              empty, full, pop, load;

  function automatic logic [L-1:0] build_frame(input logic [n-1:0] w);
`ifdef FRAME_CRC4_EN
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < n; i++) begin
      fb = c[3] ^ w[n-1-i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return {w, c};
`else
    return {w, ^w};
`endif
  endfunction

  assign head  = mem_q[rd_ptr_q[depth_log2-1:0]];
  assign frame = build_frame(head);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[depth_log2] != rd_ptr_q[depth_log2]) &&
                 (wr_ptr_q[depth_log2-1:0] == rd_ptr_q[depth_log2-1:0]);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    tx_data_d  = tx_data_q;
    tx_frame_d = tx_frame_q;
    tx_done_d  = 1'b0;
    tx_fail_d  = 1'b0;
    overflow_d = overflow_q;
    pop        = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      SEND: begin
        if (cnt_q == CW'(L - 1)) begin
          tx_frame_d = 1'b0;
          tx_data_d  = 1'b0;
          timer_d    = '0;
          state_d    = WAIT_ACK;
        end else begin
          tx_data_d = sreg_q[L-1];
          sreg_d    = {sreg_q[L-2:0], 1'b0};
          cnt_d     = cnt_q + CW'(1);
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TW'(1);
        if (ack && !nack) begin
          pop       = 1'b1;
          tx_done_d = 1'b1;
          retry_d   = '0;
          state_d   = IDLE;
        end else if (nack || timer_q == TW'(ack_timeout - 1)) begin
          if (retry_q < RW'(max_retry)) begin
            retry_d = retry_q + RW'(1);
            load    = 1'b1;
          end else begin
            pop       = 1'b1;
            tx_fail_d = 1'b1;
            retry_d   = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The first frame bit goes out on the load edge, so the shift register keeps only the rest.
    if (load) begin
      state_d    = SEND;
      tx_data_d  = frame[L-1];
      tx_frame_d = 1'b1;
      sreg_d     = {frame[L-2:0], 1'b0};
      cnt_d      = '0;
    end

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (input_valid) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q[depth_log2-1:0]] = input_num;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      tx_data_q  <= 1'b0;
      tx_frame_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_fail_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (enable) begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      tx_data_q  <= tx_data_d;
      tx_frame_q <= tx_frame_d;
      tx_done_q  <= tx_done_d;
      tx_fail_q  <= tx_fail_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_frame = tx_frame_q;
  assign tx_done  = tx_done_q;
  assign tx_fail  = tx_fail_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cordic_frame_tx.sv
// Bench for cordic_frame_tx: frame table, directed retry/timeout/overflow/enable/reset sequences, random receiver traffic.
module tb_cordic_frame_tx;
  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXR  = 3;
  localparam int unsigned TMO   = 32;
`ifdef FRAME_CRC4_EN
  localparam int unsigned L = N + 4;
`else
  localparam int unsigned L = N + 1;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0, enable = 1'b1, input_valid = 1'b0, ack = 1'b0, nack = 1'b0;
  logic [N:1]   input_num = '0;
  logic         tx_data, tx_frame, tx_done, tx_fail, overflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q [$];
  bit           push_done = 1'b0;

  cordic_frame_tx #(.n(N), .depth_log2(2), .max_retry(MAXR), .ack_timeout(TMO)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .input_valid(input_valid),
    .input_num(input_num), .ack(ack), .nack(nack), .tx_data(tx_data),
    .tx_frame(tx_frame), .tx_done(tx_done), .tx_fail(tx_fail), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0] w;
    int           d;
    logic [L-1:0] f;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference frame: parity by bit count, CRC by polynomial long division of w*x^4.
  function automatic logic [L-1:0] model_frame(input logic [N-1:0] w);
`ifdef FRAME_CRC4_EN
    logic [N+3:0] v;
    v = {w, 4'b0000};
    for (int i = N + 3; i >= 4; i--)
      if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
    return {w, v[3:0]};
`else
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(w[i]);
    return {w, ones[0]};
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] w);
    input_valid = 1'b1;
    input_num   = w;
    step;
    input_valid = 1'b0;
  endtask

  task automatic get_frame(input int budget, output logic [L-1:0] f, output int waited);
    int hi;
    waited = 0;
    hi     = 0;
    f      = '0;
    while (!tx_frame && waited < budget) begin
      step;
      waited++;
    end
    chk("frame_start", tx_frame, 1);
    for (int b = 0; b < int'(L); b++) begin
      f = {f[L-2:0], tx_data};
      if (tx_frame) hi++;
      step;
    end
    chk("frame_len", hi, L);
    chk("frame_end_frame", tx_frame, 0);
    chk("frame_end_data", tx_data, 0);
  endtask

  task automatic expect_idle(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      step;
      if (tx_frame) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic send_ack(input int d);
    repeat (d) step;
    ack = 1'b1;
    step;
    ack = 1'b0;
  endtask

  task automatic rx_proc;
    logic [L-1:0] f;
    int waited, kind, d, retries, exp_gap, guard;
    retries = 0;
    exp_gap = -1;
    guard   = 0;
    while (!(push_done && exp_q.size() == 0) && guard < 20000) begin
      if (exp_q.size() == 0) begin
        step;
        guard++;
        continue;
      end
      get_frame(60, f, waited);
      guard += waited + int'(L);
      if (exp_gap >= 0) chk("rnd_gap", waited, exp_gap);
      exp_gap = -1;
      chk("rnd_frame", f, model_frame(exp_q[0]));
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, 4);
      if (kind < 6) begin
        send_ack(d);
        chk("rnd_done", tx_done, 1);
        void'(exp_q.pop_front());
        retries = 0;
      end else if (kind < 9) begin
        repeat (d) step;
        nack = 1'b1;
        ack  = 1'($urandom_range(0, 1));
        step;
        nack = 1'b0;
        ack  = 1'b0;
        chk("rnd_nack_done", tx_done, 0);
        if (retries < int'(MAXR)) begin
          retries++;
          chk("rnd_nack_nofail", tx_fail, 0);
        end else begin
          chk("rnd_nack_fail", tx_fail, 1);
          void'(exp_q.pop_front());
          retries = 0;
        end
      end else begin
        if (retries < int'(MAXR)) begin
          retries++;
          exp_gap = int'(TMO);
        end else begin
          repeat (TMO) step;
          chk("rnd_tmo_fail", tx_fail, 1);
          void'(exp_q.pop_front());
          retries = 0;
        end
      end
      guard += 40;
    end
    chk("rnd_guard", guard < 20000, 1);
  endtask

  task automatic push_proc;
    logic [N-1:0] w;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 25)) step;
      if (exp_q.size() < DEPTH) begin
        w = N'($urandom);
        exp_q.push_back(w);
        push(w);
      end
    end
    push_done = 1'b1;
  endtask

  initial begin
    logic [L-1:0] f, ef;
    int waited, hi, guard;

`ifdef FRAME_CRC4_EN
    tbl[0] = '{w: 16'h0001, d: 3, f: {16'h0001, 4'b0011}};
    tbl[1] = '{w: 16'h8000, d: 0, f: {16'h8000, 4'b0011}};
    tbl[2] = '{w: 16'h0002, d: 1, f: {16'h0002, 4'b0110}};
    tbl[3] = '{w: 16'h0010, d: 2, f: {16'h0010, 4'b0101}};
    tbl[4] = '{w: 16'h0000, d: 0, f: {16'h0000, 4'b0000}};
    tbl[5] = '{w: 16'h0003, d: 4, f: {16'h0003, 4'b0101}};
`else
    tbl[0] = '{w: 16'h0F15, d: 3, f: 17'b0000111100010101_1};
    tbl[1] = '{w: 16'h8000, d: 0, f: {16'h8000, 1'b1}};
    tbl[2] = '{w: 16'h1234, d: 1, f: {16'h1234, 1'b1}};
    tbl[3] = '{w: 16'hFFFF, d: 2, f: {16'hFFFF, 1'b0}};
    tbl[4] = '{w: 16'h0000, d: 0, f: {16'h0000, 1'b0}};
    tbl[5] = '{w: 16'hA5A5, d: 4, f: {16'hA5A5, 1'b0}};
`endif

    repeat (3) step;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_fail", tx_fail, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    step;

    // Single word: latency, frame content, ack 3 cycles after frame end.
    input_valid = 1'b1;
    input_num   = 16'h0F15;
    step;
    input_valid = 1'b0;
    chk("a_lat_k", tx_frame, 0);
    step;
    chk("a_lat_k1_frame", tx_frame, 1);
    chk("a_lat_k1_msb", tx_data, 0);
    get_frame(4, f, waited);
    chk("a_frame", f, model_frame(16'h0F15));
    send_ack(3);
    chk("a_done", tx_done, 1);
    step;
    chk("a_done_pulse", tx_done, 0);
    expect_idle("a_empty", 40);

    // Nack twice then ack.
    push(16'h8000);
    for (int r = 0; r < 3; r++) begin
      get_frame(10, f, waited);
      chk("b_frame", f, model_frame(16'h8000));
      if (r < 2) begin
        step;
        nack = 1'b1;
        step;
        nack = 1'b0;
        chk("b_nack_done", tx_done, 0);
        chk("b_nack_fail", tx_fail, 0);
      end else begin
        send_ack(1);
        chk("b_done", tx_done, 1);
        chk("b_fail", tx_fail, 0);
      end
    end
    expect_idle("b_empty", 40);

    // Silent receiver: 4 attempts, each followed by a full timeout, then drop.
    push(16'h1234);
    for (int a = 0; a < 4; a++) begin
      get_frame(40, f, waited);
      if (a > 0) chk("c_gap", waited, TMO);
      chk("c_frame", f, model_frame(16'h1234));
    end
    repeat (TMO - 1) step;
    chk("c_fail_early", tx_fail, 0);
    step;
    chk("c_fail", tx_fail, 1);
    step;
    chk("c_fail_pulse", tx_fail, 0);
    expect_idle("c_empty", 40);

    // Burst of 6 into a 4-deep FIFO while the first frame goes out.
    f = '0;
    hi = 0;
    input_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      input_num = N'(i);
      step;
      if (tx_frame) begin
        f = {f[L-2:0], tx_data};
        hi++;
      end
    end
    input_valid = 1'b0;
    chk("d_overflow", overflow, 1);
    guard = 0;
    while (hi < int'(L) && guard < 40) begin
      step;
      guard++;
      if (tx_frame) begin
        f = {f[L-2:0], tx_data};
        hi++;
      end
    end
    step;
    chk("d_frame1", f, model_frame(16'h0001));
    chk("d_frame1_end", tx_frame, 0);
    send_ack(0);
    chk("d_done1", tx_done, 1);
    for (int w = 2; w <= 4; w++) begin
      get_frame(10, f, waited);
      chk("d_frame", f, model_frame(N'(w)));
      send_ack(0);
      chk("d_done", tx_done, 1);
    end
    expect_idle("d_lost", 40);
    chk("d_overflow_sticky", overflow, 1);

    // Enable low for 10 cycles mid-frame; inputs during the freeze are ignored.
    ef = model_frame(16'hC3A5);
    push(16'hC3A5);
    waited = 0;
    while (!tx_frame && waited < 5) begin
      step;
      waited++;
    end
    f = '0;
    for (int b = 0; b < 5; b++) begin
      f = {f[L-2:0], tx_data};
      step;
    end
    enable      = 1'b0;
    input_valid = 1'b1;
    input_num   = 16'hFFFF;
    ack         = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step;
      chk("e_hold_frame", tx_frame, 1);
      chk("e_hold_data", tx_data, ef[L-6]);
    end
    enable      = 1'b1;
    input_valid = 1'b0;
    ack         = 1'b0;
    for (int b = 5; b < int'(L); b++) begin
      f = {f[L-2:0], tx_data};
      step;
    end
    chk("e_frame", f, ef);
    chk("e_frame_end", tx_frame, 0);
    send_ack(0);
    chk("e_done", tx_done, 1);
    expect_idle("e_no_push", 40);

    // Asynchronous reset in the middle of a frame.
    push(16'h5A5A);
    push(16'h0F0F);
    repeat (3) step;
    chk("f_pre_frame", tx_frame, 1);
    #2 resetn = 1'b0;
    #1;
    chk("f_rst_frame", tx_frame, 0);
    chk("f_rst_data", tx_data, 0);
    chk("f_rst_overflow", overflow, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    expect_idle("f_empty", 40);

    // Table of single-word frames.
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].w);
      get_frame(10, f, waited);
      chk("tbl_frame", f, tbl[i].f);
      send_ack(tbl[i].d);
      chk("tbl_done", tx_done, 1);
    end

    // Random traffic against the queue model.
    fork
      push_proc();
      rx_proc();
    join
    chk("rnd_overflow", overflow, 0);
    chk("rnd_left", exp_q.size(), 0);
    expect_idle("rnd_idle", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
